// File: rtl/pj_mem_ctl.sv
// rtl/pj_mem_ctl.sv - bus interface unit to synchronous SRAM controller
// Single/burst reads and writes with optional wait states and error acks.
module pj_mem_ctl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_LIMIT  = 32'h00FF_FFFF
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        pj_tv,
  input  logic        pj_ale,
  input  logic [31:0] pj_addr,
  input  logic [3:0]  pj_type,
  input  logic [1:0]  pj_size,
  input  logic [31:0] pj_data_out,
  output logic [31:0] pj_data_in,
  output logic [1:0]  pj_ack,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_WAIT  = 6'b000010,
    ST_RBEAT = 6'b000100,
    ST_WBEAT = 6'b001000,
    ST_WACK  = 6'b010000,
    ST_ERR   = 6'b100000
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [1:0]  type_q;
  logic [1:0]  size_q;
  logic        err_q;
  logic [3:0]  wait_cnt_q;
  logic [1:0]  beat_q;
  logic        rd_ack_q;
  logic        capture;
  logic        cap_err;
  logic        last_beat;
  logic [1:0]  word_off;
  logic [29:0] beat_addr;
  logic [3:0]  beat_be;
  logic        unused_type;

  assign unused_type = ^pj_type[3:2];

  assign cap_err = (pj_addr > ADDR_LIMIT) || (pj_size == 2'b11) ||
                   ((pj_size == 2'b01) && pj_addr[0]) ||
                   ((pj_size == 2'b10) && (pj_addr[1:0] != 2'b00));

  assign last_beat = type_q[1] || (beat_q == 2'd3);
  // Bursts wrap inside the 16-byte line, starting from the requested word
  assign word_off  = addr_q[3:2] + beat_q;
  assign beat_addr = {addr_q[31:4], word_off};

  always_comb begin
    beat_be = 4'hF;
    if (type_q[1]) begin
      case (size_q)
        2'b00:   beat_be = 4'b0001 << addr_q[1:0];
        2'b01:   beat_be = addr_q[1] ? 4'b1100 : 4'b0011;
        default: beat_be = 4'hF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    pj_ack     = 2'b00;
    pj_data_in = 32'h0;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 30'h0;
    mem_be     = 4'h0;
    mem_wdata  = 32'h0;
    // SRAM data arrives one cycle after each read beat
    if (rd_ack_q) begin
      pj_ack     = 2'b01;
      pj_data_in = mem_rdata;
    end
    case (state_q)
      ST_IDLE: begin
        if (pj_tv && !pj_ale) begin
          capture = 1'b1;
          if (HAS_WAIT)        state_d = ST_WAIT;
          else if (cap_err)    state_d = ST_ERR;
          else if (pj_type[0]) state_d = ST_WBEAT;
          else                 state_d = ST_RBEAT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd1) begin
          if (err_q)          state_d = ST_ERR;
          else if (type_q[0]) state_d = ST_WBEAT;
          else                state_d = ST_RBEAT;
        end
      end
      ST_RBEAT: begin
        mem_cs   = 1'b1;
        mem_addr = beat_addr;
        mem_be   = beat_be;
        if (last_beat) state_d = ST_WACK;
      end
      ST_WBEAT: begin
        mem_cs    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_be    = beat_be;
        mem_wdata = pj_data_out;
        state_d   = ST_WACK;
      end
      ST_WACK: begin
        pj_ack = 2'b01;
        if (type_q[0] && !last_beat) state_d = ST_WBEAT;
        else                         state_d = ST_IDLE;
      end
      ST_ERR: begin
        pj_ack  = 2'b10;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      addr_q     <= 32'h0;
      type_q     <= 2'b00;
      size_q     <= 2'b00;
      err_q      <= 1'b0;
      wait_cnt_q <= 4'h0;
      beat_q     <= 2'd0;
      rd_ack_q   <= 1'b0;
    end else begin
      rd_ack_q <= (state_q == ST_RBEAT);
      if (capture) begin
        addr_q     <= pj_addr;
        type_q     <= pj_type[1:0];
        size_q     <= pj_size;
        err_q      <= cap_err;
        wait_cnt_q <= WAIT_INIT;
        beat_q     <= 2'd0;
      end else begin
        if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q - 4'd1;
        if (((state_q == ST_RBEAT) || ((state_q == ST_WACK) && type_q[0])) && !last_beat)
          beat_q <= beat_q + 2'd1;
      end
    end
  end

endmodule
